// File: rtl/ips_debounce.sv
// ips_debounce: synchronise and debounce active-low proximity sensor lines
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_ips_raw_n  raw sensor lines, active-low (1 = nothing detected)
//   o_ips_detect debounced detection, active-high (1 = metal)
//   o_ips_change one-cycle strobe when any o_ips_detect bit changes after startup
//   o_ips_valid  sticky flag, high once the startup qualification window has elapsed
module ips_debounce #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 3)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_ips_raw_n,
    output logic [CHANNELS-1:0] o_ips_detect,
    output logic                o_ips_change,
    output logic                o_ips_valid
);
    typedef enum logic {ST_STABLE, ST_PENDING} state_t;
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_START = CNT_W'(DEBOUNCE_CYCLES + 2);
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [CHANNELS-1:0] r_stable;
    logic [CHANNELS-1:0] w_accept;
    state_t              r_state     [CHANNELS];
    state_t              w_state_nxt [CHANNELS];
    logic [CNT_W-1:0]    r_cnt       [CHANNELS];
    logic [CNT_W-1:0]    w_cnt_nxt   [CHANNELS];
    logic [CNT_W-1:0]    r_start;
    logic                r_valid;
    logic                r_change;
    // The first mismatching sample only arms PENDING; the count runs from
    // there, so a new level is accepted DEBOUNCE_CYCLES+2 edges after the pin moves.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_state_nxt[i] = ST_STABLE;
            w_cnt_nxt[i]   = '0;
            w_accept[i]    = 1'b0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_state[i] == ST_STABLE) begin
                    w_state_nxt[i] = ST_PENDING;
                end else if (r_cnt[i] == C_LAST) begin
                    w_accept[i] = 1'b1;
                end else begin
                    w_state_nxt[i] = ST_PENDING;
                    w_cnt_nxt[i]   = r_cnt[i] + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_stable <= '1;
            r_start  <= '0;
            r_valid  <= 1'b0;
            r_change <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1  <= i_ips_raw_n;
            r_sync2  <= r_sync1;
            r_stable <= r_stable ^ w_accept;
            // Old valid gates the strobe so startup qualification stays silent.
            r_change <= (|w_accept) & r_valid;
            if (r_start != C_START) r_start <= r_start + 1'b1;
            if (r_start == C_START) r_valid <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end
    assign o_ips_detect = ~r_stable;
    assign o_ips_change = r_change;
    assign o_ips_valid  = r_valid;
endmodule

// File: tb/tb_ips_debounce.sv
// tb_ips_debounce: scoreboard bench for ips_debounce with DEBOUNCE_CYCLES = 8
module tb_ips_debounce;
    localparam int DC = 8;
    typedef struct packed {
        int          e;
        logic [63:0] tag;
        logic [3:0]  det;
        logic        chg;
        logic        val;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw_n = 4'b0000;
    logic [3:0] det;
    logic       chg;
    logic       val;
    int         edge_n = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         e0;
    int         k;
    exp_t       sb[$];
    exp_t       it;
    ips_debounce #(.CHANNELS(4), .DEBOUNCE_CYCLES(DC)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_ips_raw_n(raw_n),
        .o_ips_detect(det),
        .o_ips_change(chg),
        .o_ips_valid(val)
    );
    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;
    task automatic check_eq(input logic [95:0] tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %0s edge %0d: got %0h want %0h", tag, edge_n - 1, got, exp);
        end
    endtask
    task automatic push_range(input int a, input int b, input logic [63:0] tag,
                              input logic [3:0] d, input logic c, input logic v);
        for (int e = a; e <= b; e++) sb.push_back('{e: e, tag: tag, det: d, chg: c, val: v});
    endtask
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].e < edge_n) begin
            it = sb.pop_front();
            check_eq({it.tag, "_det"}, 32'(det), 32'(it.det));
            check_eq({it.tag, "_chg"}, 32'(chg), 32'(it.chg));
            check_eq({it.tag, "_val"}, 32'(val), 32'(it.val));
        end
    end
    initial begin
        run(2);
        push_range(edge_n, edge_n + 1, "reset", 4'b0000, 1'b0, 1'b0);
        run(2);
        rst_n = 1'b1;
        e0 = edge_n;
        push_range(e0, e0 + 9, "startup", 4'b0000, 1'b0, 1'b0);
        push_range(e0 + 10, e0 + 12, "startup", 4'b1111, 1'b0, 1'b1);
        run(13);
        raw_n = 4'b1111;
        e0 = edge_n;
        push_range(e0, e0 + 9, "release", 4'b1111, 1'b0, 1'b1);
        push_range(e0 + 10, e0 + 10, "release", 4'b0000, 1'b1, 1'b1);
        push_range(e0 + 11, e0 + 12, "release", 4'b0000, 1'b0, 1'b1);
        run(13);
        raw_n = 4'b1101;
        e0 = edge_n;
        push_range(e0, e0 + 20, "glitch", 4'b0000, 1'b0, 1'b1);
        run(7);
        raw_n = 4'b1111;
        run(14);
        raw_n = 4'b1110;
        e0 = edge_n;
        push_range(e0, e0 + 9, "step", 4'b0000, 1'b0, 1'b1);
        push_range(e0 + 10, e0 + 10, "step", 4'b0001, 1'b1, 1'b1);
        push_range(e0 + 11, e0 + 12, "step", 4'b0001, 1'b0, 1'b1);
        run(13);
        e0 = edge_n;
        k = e0 + 7;
        push_range(e0, k + 9, "bounce", 4'b0001, 1'b0, 1'b1);
        push_range(k + 10, k + 10, "bounce", 4'b0101, 1'b1, 1'b1);
        push_range(k + 11, k + 12, "bounce", 4'b0101, 1'b0, 1'b1);
        raw_n = 4'b1010; run(3);
        raw_n = 4'b1110; run(2);
        raw_n = 4'b1010; run(1);
        raw_n = 4'b1110; run(1);
        raw_n = 4'b1010; run(13);
        raw_n = 4'b1110;
        e0 = edge_n;
        push_range(e0, e0 + 9, "unset", 4'b0101, 1'b0, 1'b1);
        push_range(e0 + 10, e0 + 10, "unset", 4'b0001, 1'b1, 1'b1);
        push_range(e0 + 11, e0 + 12, "unset", 4'b0001, 1'b0, 1'b1);
        run(13);
        raw_n = 4'b0010;
        e0 = edge_n;
        push_range(e0, e0 + 9, "simul", 4'b0001, 1'b0, 1'b1);
        push_range(e0 + 10, e0 + 10, "simul", 4'b1101, 1'b1, 1'b1);
        push_range(e0 + 11, e0 + 12, "simul", 4'b1101, 1'b0, 1'b1);
        run(13);
        raw_n = 4'b1111;
        e0 = edge_n;
        push_range(e0, e0 + 9, "clear", 4'b1101, 1'b0, 1'b1);
        push_range(e0 + 10, e0 + 10, "clear", 4'b0000, 1'b1, 1'b1);
        push_range(e0 + 11, e0 + 12, "clear", 4'b0000, 1'b0, 1'b1);
        run(13);
        raw_n = 4'b1110;
        e0 = edge_n;
        push_range(e0, e0 + 5, "midcount", 4'b0000, 1'b0, 1'b1);
        run(6);
        #1 rst_n = 1'b0;
        #1 check_eq("rst_async", {29'b0, det == 4'b0000, chg, val}, 32'h4);
        push_range(edge_n, edge_n + 1, "rstmid", 4'b0000, 1'b0, 1'b0);
        run(2);
        rst_n = 1'b1;
        e0 = edge_n;
        push_range(e0, e0 + 9, "relaunch", 4'b0000, 1'b0, 1'b0);
        push_range(e0 + 10, e0 + 12, "relaunch", 4'b0001, 1'b0, 1'b1);
        run(13);
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        check_eq("drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
